// File: rtl/regf_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regf_pkg : phase encodings and buffered-write record shared by the RAM and its write front end
// Rev 1.0
// ----------------------------------------------------------------------------
package regf_pkg;

    localparam int REGF_AW = 6;
    localparam int REGF_DW = 32;

    localparam logic READ_PH  = 1'b0;
    localparam logic WRITE_PH = 1'b1;

    typedef struct packed {
        logic               enable;
        logic [REGF_AW-1:0] addr_a;
        logic [REGF_AW-1:0] addr_b;
        logic [REGF_DW-1:0] data_a;
        logic [REGF_DW-1:0] data_b;
    } wr_entry_t;

    // The RAM has one shared write enable, so a single-port or same-address
    // request is folded into an entry whose two slots are identical.
    function automatic wr_entry_t normalise_req(
        input logic               wen_a,
        input logic               wen_b,
        input logic [REGF_AW-1:0] addr_a,
        input logic [REGF_AW-1:0] addr_b,
        input logic [REGF_DW-1:0] data_a,
        input logic [REGF_DW-1:0] data_b
    );
        wr_entry_t e;
        e.enable = wen_a | wen_b;
        e.addr_a = addr_a;
        e.addr_b = addr_b;
        e.data_a = data_a;
        e.data_b = data_b;
        if (wen_b && (!wen_a || (addr_a == addr_b))) begin
            e.addr_a = addr_b;
            e.data_a = data_b;
        end else if (wen_a && !wen_b) begin
            e.addr_b = addr_a;
            e.data_b = data_a;
        end
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regf_fwd_mux.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regf_fwd_mux : youngest-match forwarding of buffered writes onto one read port
// Rev 1.0
// ----------------------------------------------------------------------------
module regf_fwd_mux
    import regf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = REGF_AW,
    parameter int DW    = REGF_DW
) (
    input  logic [AW-1:0]       rd_addr,
    input  logic [DW-1:0]       ram_rd_data,
    input  logic [DEPTH-1:0]    entry_valid,
    input  logic [DEPTH*AW-1:0] entry_addr_a,
    input  logic [DEPTH*AW-1:0] entry_addr_b,
    input  logic [DEPTH*DW-1:0] entry_data_a,
    input  logic [DEPTH*DW-1:0] entry_data_b,
    output logic [DW-1:0]       rd_data
);

    // Entries arrive oldest first; later matches override earlier ones, and
    // slot b is tested after slot a so it wins within an entry.
    always_comb begin
        rd_data = ram_rd_data;
        for (int k = 0; k < DEPTH; k++) begin
            if (entry_valid[k] && (entry_addr_a[k*AW +: AW] == rd_addr))
                rd_data = entry_data_a[k*DW +: DW];
            if (entry_valid[k] && (entry_addr_b[k*AW +: AW] == rd_addr))
                rd_data = entry_data_b[k*DW +: DW];
        end
    end

endmodule
`default_nettype wire

// File: rtl/regf_wr_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regf_wr_buffer : write FIFO that drains into the multipumped RAM on WRITE phases and forwards pending data
// Rev 1.0
// ----------------------------------------------------------------------------
module regf_wr_buffer
    import regf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = REGF_AW,
    parameter int DW    = REGF_DW
) (
    input  logic          i_clk_multipump,
    input  logic          i_reset_n,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic          i_req_wen_a,
    input  logic          i_req_wen_b,
    input  logic [AW-1:0] i_req_addr_a,
    input  logic [AW-1:0] i_req_addr_b,
    input  logic [DW-1:0] i_req_data_a,
    input  logic [DW-1:0] i_req_data_b,
    output logic          o_wen,
    output logic [AW-1:0] o_wr_addr_a,
    output logic [AW-1:0] o_wr_addr_b,
    output logic [DW-1:0] o_wr_data_a,
    output logic [DW-1:0] o_wr_data_b,
    output logic          o_phase,
    input  logic [AW-1:0] i_rd_addr_a,
    input  logic [AW-1:0] i_rd_addr_b,
    input  logic [AW-1:0] i_rd_addr_c,
    input  logic [AW-1:0] i_rd_addr_d,
    input  logic [DW-1:0] i_ram_rd_data_a,
    input  logic [DW-1:0] i_ram_rd_data_b,
    input  logic [DW-1:0] i_ram_rd_data_c,
    input  logic [DW-1:0] i_ram_rd_data_d,
    output logic [DW-1:0] o_rd_data_a,
    output logic [DW-1:0] o_rd_data_b,
    output logic [DW-1:0] o_rd_data_c,
    output logic [DW-1:0] o_rd_data_d
);

    localparam int          PW         = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    logic            phase;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    wr_entry_t       mem [DEPTH];
    wr_entry_t       req_entry;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    assign req_entry = normalise_req(i_req_wen_a, i_req_wen_b, i_req_addr_a, i_req_addr_b,
                                     i_req_data_a, i_req_data_b);

    assign full        = (count == FULL_COUNT);
    assign empty       = (count == '0);
    assign o_req_ready = !full;
    // Requests with both enables low are handshaken but never stored.
    assign push        = i_req_valid && !full && req_entry.enable;
    assign pop         = (phase == WRITE_PH) && !empty;

    assign o_wen       = pop;
    assign o_phase     = phase;
    assign o_wr_addr_a = empty ? '0 : mem[rd_ptr].addr_a;
    assign o_wr_addr_b = empty ? '0 : mem[rd_ptr].addr_b;
    assign o_wr_data_a = empty ? '0 : mem[rd_ptr].data_a;
    assign o_wr_data_b = empty ? '0 : mem[rd_ptr].data_b;

    always_ff @(posedge i_clk_multipump) begin
        if (!i_reset_n) begin
            phase  <= READ_PH;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            phase <= ~phase;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk_multipump) begin
        if (push)
            mem[wr_ptr] <= req_entry;
    end

    // Present the FIFO in age order (index 0 = head) for the forwarding muxes.
    logic [PW-1:0]       idx;
    logic [DEPTH-1:0]    ord_valid;
    logic [DEPTH*AW-1:0] ord_addr_a;
    logic [DEPTH*AW-1:0] ord_addr_b;
    logic [DEPTH*DW-1:0] ord_data_a;
    logic [DEPTH*DW-1:0] ord_data_b;

    always_comb begin
        idx        = '0;
        ord_valid  = '0;
        ord_addr_a = '0;
        ord_addr_b = '0;
        ord_data_a = '0;
        ord_data_b = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx                    = rd_ptr + PW'(k);
            ord_valid[k]           = ((PW+1)'(k) < count) && mem[idx].enable;
            ord_addr_a[k*AW +: AW] = mem[idx].addr_a;
            ord_addr_b[k*AW +: AW] = mem[idx].addr_b;
            ord_data_a[k*DW +: DW] = mem[idx].data_a;
            ord_data_b[k*DW +: DW] = mem[idx].data_b;
        end
    end

    logic [AW-1:0] rd_addr     [4];
    logic [DW-1:0] ram_rd_data [4];
    logic [DW-1:0] rd_data     [4];

    assign rd_addr[0]     = i_rd_addr_a;
    assign rd_addr[1]     = i_rd_addr_b;
    assign rd_addr[2]     = i_rd_addr_c;
    assign rd_addr[3]     = i_rd_addr_d;
    assign ram_rd_data[0] = i_ram_rd_data_a;
    assign ram_rd_data[1] = i_ram_rd_data_b;
    assign ram_rd_data[2] = i_ram_rd_data_c;
    assign ram_rd_data[3] = i_ram_rd_data_d;
    assign o_rd_data_a    = rd_data[0];
    assign o_rd_data_b    = rd_data[1];
    assign o_rd_data_c    = rd_data[2];
    assign o_rd_data_d    = rd_data[3];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_fwd
            regf_fwd_mux #(
                .DEPTH (DEPTH),
                .AW    (AW),
                .DW    (DW)
            ) u_fwd_mux (
                .rd_addr      (rd_addr[gi]),
                .ram_rd_data  (ram_rd_data[gi]),
                .entry_valid  (ord_valid),
                .entry_addr_a (ord_addr_a),
                .entry_addr_b (ord_addr_b),
                .entry_data_a (ord_data_a),
                .entry_data_b (ord_data_b),
                .rd_data      (rd_data[gi])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regf_wr_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_regf_wr_buffer : directed and random stimulus against a queue model of the write buffer
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_regf_wr_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 6;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, wen_a, wen_b, wen, phase;
    logic [AW-1:0] addr_a, addr_b, wr_addr_a, wr_addr_b;
    logic [DW-1:0] data_a, data_b, wr_data_a, wr_data_b;
    logic [AW-1:0] rd_addr  [4];
    logic [DW-1:0] ram_data [4];
    logic [DW-1:0] rd_data  [4];

    always #5 clk = ~clk;

    regf_wr_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .i_clk_multipump (clk),
        .i_reset_n       (rst_n),
        .i_req_valid     (req_valid),
        .o_req_ready     (req_ready),
        .i_req_wen_a     (wen_a),
        .i_req_wen_b     (wen_b),
        .i_req_addr_a    (addr_a),
        .i_req_addr_b    (addr_b),
        .i_req_data_a    (data_a),
        .i_req_data_b    (data_b),
        .o_wen           (wen),
        .o_wr_addr_a     (wr_addr_a),
        .o_wr_addr_b     (wr_addr_b),
        .o_wr_data_a     (wr_data_a),
        .o_wr_data_b     (wr_data_b),
        .o_phase         (phase),
        .i_rd_addr_a     (rd_addr[0]),
        .i_rd_addr_b     (rd_addr[1]),
        .i_rd_addr_c     (rd_addr[2]),
        .i_rd_addr_d     (rd_addr[3]),
        .i_ram_rd_data_a (ram_data[0]),
        .i_ram_rd_data_b (ram_data[1]),
        .i_ram_rd_data_c (ram_data[2]),
        .i_ram_rd_data_d (ram_data[3]),
        .o_rd_data_a     (rd_data[0]),
        .o_rd_data_b     (rd_data[1]),
        .o_rd_data_c     (rd_data[2]),
        .o_rd_data_d     (rd_data[3])
    );

    typedef struct {
        logic [AW-1:0] aa;
        logic [AW-1:0] ab;
        logic [DW-1:0] da;
        logic [DW-1:0] db;
    } ent_t;

    ent_t q[$];
    logic mph;
    bit   held;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_model();
        ent_t          h;
        logic [DW-1:0] e;
        chk("ready", req_ready, q.size() < DEPTH);
        chk("wen",   wen,       mph && (q.size() != 0));
        chk("phase", phase,     mph);
        if (q.size() != 0) h = q[0];
        else               h = '{aa: '0, ab: '0, da: '0, db: '0};
        chk("wr_addr_a", wr_addr_a, h.aa);
        chk("wr_addr_b", wr_addr_b, h.ab);
        chk("wr_data_a", wr_data_a, h.da);
        chk("wr_data_b", wr_data_b, h.db);
        for (int p = 0; p < 4; p++) begin
            e = ram_data[p];
            foreach (q[k]) begin
                if (q[k].aa == rd_addr[p]) e = q[k].da;
                if (q[k].ab == rd_addr[p]) e = q[k].db;
            end
            chk($sformatf("fwd%0d", p), rd_data[p], e);
        end
    endtask

    // One clock: check outputs mid-cycle, then advance the model at the edge.
    task automatic step();
        bit   do_push, do_pop;
        ent_t n;
        @(negedge clk);
        compare_model();
        do_push = rst_n && req_valid && (q.size() < DEPTH) && (wen_a || wen_b);
        do_pop  = rst_n && mph && (q.size() != 0);
        held    = rst_n && req_valid && (q.size() >= DEPTH);
        n = '{aa: addr_a, ab: addr_b, da: data_a, db: data_b};
        if (wen_a && !wen_b) begin
            n.ab = addr_a; n.db = data_a;
        end else if (wen_b && (!wen_a || addr_a == addr_b)) begin
            n.aa = addr_b; n.da = data_b;
        end
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            mph = 1'b0;
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(n);
            mph = !mph;
        end
        #1;
    endtask

    task automatic set_req(input logic v, input logic wa, input logic wb,
                           input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                           input logic [DW-1:0] da, input logic [DW-1:0] db);
        req_valid = v; wen_a = wa; wen_b = wb;
        addr_a = aa; addr_b = ab; data_a = da; data_b = db;
    endtask

    initial begin
        int rate;
        rst_n = 1'b0;
        mph   = 1'b0;
        held  = 1'b0;
        set_req(0, 0, 0, '0, '0, '0, '0);
        for (int p = 0; p < 4; p++) begin
            rd_addr[p]  = '0;
            ram_data[p] = '0;
        end
        @(posedge clk); #1;
        step();

        // Reset state.
        rst_n       = 1'b1;
        rd_addr[0]  = 6'd5;
        ram_data[0] = 32'h1234_5678;
        #1;
        chk("rst_ready",   req_ready, 1);
        chk("rst_wen",     wen,       0);
        chk("rst_phase",   phase,     0);
        chk("rst_wr_addr", wr_addr_a, 0);
        chk("rst_wr_data", wr_data_b, 0);
        chk("rst_fwd",     rd_data[0], 32'h1234_5678);

        // r5 = 0x11 in a READ cycle: written on the next (WRITE) cycle.
        set_req(1, 1, 0, 6'd5, 6'd0, 32'h11, 32'h0);
        step();
        set_req(0, 0, 0, '0, '0, '0, '0);
        #1;
        chk("r5_wen",    wen,       1);
        chk("r5_addr_a", wr_addr_a, 5);
        chk("r5_addr_b", wr_addr_b, 5);
        chk("r5_data_a", wr_data_a, 32'h11);
        chk("r5_data_b", wr_data_b, 32'h11);
        chk("r5_fwd",    rd_data[0], 32'h11);
        step();
        #1;
        chk("r5_drained_ready", req_ready, 1);
        chk("r5_drained_addr",  wr_addr_a, 0);

        // Same-address pair: b wins on both slots and on forwarding.
        rd_addr[1]  = 6'd3;
        ram_data[1] = 32'h0;
        set_req(1, 1, 1, 6'd3, 6'd3, 32'hA, 32'hB);
        step();
        set_req(0, 0, 0, '0, '0, '0, '0);
        #1;
        chk("r3_wen",    wen,        1);
        chk("r3_data_a", wr_data_a,  32'hB);
        chk("r3_data_b", wr_data_b,  32'hB);
        chk("r3_fwd",    rd_data[1], 32'hB);
        step();

        // r7 = 1 then r7 = 2 observed on read port c.
        rd_addr[2]  = 6'd7;
        ram_data[2] = 32'h0;
        set_req(1, 1, 0, 6'd7, 6'd0, 32'h1, 32'h0);
        step();
        #1;
        chk("r7_first", rd_data[2], 32'h1);
        set_req(1, 0, 1, 6'd0, 6'd7, 32'h0, 32'h2);
        step();
        set_req(0, 0, 0, '0, '0, '0, '0);
        #1;
        chk("r7_second", rd_data[2], 32'h2);
        step();
        #1;
        chk("r7_head", rd_data[2], 32'h2);
        step();
        ram_data[2] = 32'h55;
        #1;
        chk("r7_ram", rd_data[2], 32'h55);

        // Build up three entries, then reset drops them without draining.
        for (int i = 0; i < 5; i++) begin
            set_req(1, 1, 0, 6'(10 + i), 6'd0, 32'(100 + i), 32'h0);
            step();
        end
        set_req(0, 0, 0, '0, '0, '0, '0);
        chk("pre_reset_depth", q.size(), 3);
        rd_addr[3]  = 6'd13;
        ram_data[3] = 32'h99;
        rst_n       = 1'b0;
        step();
        #1;
        chk("mid_rst_wen",   wen,        0);
        chk("mid_rst_ready", req_ready,  1);
        chk("mid_rst_phase", phase,      0);
        chk("mid_rst_fwd",   rd_data[3], 32'h99);
        rst_n = 1'b1;

        // Randomized traffic with varying request density and rare resets.
        rate = 100;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 3))
                    0:       rate = 20;
                    1:       rate = 50;
                    2:       rate = 90;
                    default: rate = 100;
                endcase
            end
            rst_n = ($urandom_range(0, 499) != 0);
            if (!held) begin
                req_valid = ($urandom_range(0, 99) < rate);
                wen_a     = ($urandom_range(0, 9) < 7);
                wen_b     = ($urandom_range(0, 9) < 7);
                addr_a    = AW'($urandom_range(0, 7));
                addr_b    = AW'($urandom_range(0, 7));
                data_a    = $urandom;
                data_b    = $urandom;
            end
            for (int p = 0; p < 4; p++) begin
                rd_addr[p]  = AW'($urandom_range(0, 7));
                ram_data[p] = $urandom;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
